node_packet_sender: RTL and testbench
=====================================

# node_packet_sender

Node-side transmit port that feeds one inbound channel of the 4-port router. Node logic hands it whole 32-bit packets; the block queues them in a small FIFO. Each packet is serialized into four byte transfers on the router's put/payload/free handshake. One instance sits in front of each router port.

## Interface
Parameters:
- `NODEID`, default 0: this node's 4-bit ID; used only by the self-drop feature.
- `FIFO_DEPTH`, default 4: packet FIFO depth. Must be a power of two, at least 2.

Ports:
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `pkt_valid`  in  1  — node offers a packet this cycle.
- `pkt_data`  in  32  — packet. Field layout: [31:28] source, [27:24] destination, [23:0] data.
- `pkt_ready`  out  1  — FIFO not full. Combinational from the registered count.
- `router_free`  in  1  — router inbound buffer is free; driven from the router's `free_inbound[n]`.
- `put_router`  out  1  — byte transfer in progress; drives the router's `put_inbound[n]`. Registered.
- `payload_router`  out  8  — current byte; drives the router's `payload_inbound[n]`. Registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  — packets queued, excluding the one in flight.
- `sent_count`  out  16  — packets fully transmitted; wraps modulo 2^16.
- `drop_count`  out  8  — self-addressed packets dropped; saturates at 255.

## Operation
- Enqueue: a packet is accepted on any edge where `pkt_valid` and `pkt_ready` are both high. There is no pass-through; the packet always goes through the FIFO.
- FSM states:
  - IDLE → SEND when `fifo_count`>0 and `router_free`=1 at the edge ("launch").
  - SEND holds a byte index of 0..3 and stays for 4 cycles.
  - SEND at index 3 → GAP.
  - GAP → SEND on the launch condition; otherwise GAP → IDLE.
- At launch:
  - The FIFO head is popped into a 32-bit shift register.
  - `put_router`=1.
  - `payload_router` = [31:24] first, then [23:16], then [15:8], then [7:0] (MSB byte first).
- In GAP and IDLE: `put_router`=0 and `payload_router`=8'h00.
- `router_free` is sampled only at launch. A drop of `router_free` during SEND is ignored and the transfer completes.
- `sent_count` increments on the edge leaving SEND at index 3.
- Simultaneous push and launch: the count is unchanged, and the head and tail pointers both advance.
- Full: `pkt_ready`=0. A `pkt_valid` while full is ignored and nothing is lost internally.
- Empty: the FSM stays in IDLE regardless of `router_free`.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset, asynchronous and possible mid-operation:
  - State goes to IDLE; FIFO is emptied; all counters go to 0.
  - `put_router`=0, `payload_router`=0.
  - Any in-flight packet is abandoned; its partial transfer is not resumed.

## Timing
- Reset values:
  - `put_router`=0, `payload_router`=0.
  - `fifo_count`=0, `sent_count`=0, `drop_count`=0.
  - `pkt_ready`=1.
- Latency: a packet accepted at edge T onto an empty FIFO, with `router_free` high, launches at T+1.
  - `put_router` is high during cycles T+1..T+4.
  - Byte k is visible in cycle T+1+k.
- Back-to-back packets: `put_router` is low for exactly 1 cycle (GAP), so the packet period is 5 cycles.
- If `router_free` is low in GAP, launch waits for the first edge where it is high.

## Configuration
- Macro: `NODE_SELF_DROP_EN`.
- Defined:
  - An accepted packet with `pkt_data[27:24]`==NODEID is discarded instead of enqueued.
  - `pkt_ready` behaviour is unchanged.
  - `drop_count` increments, saturating at 255.
  - If a self-addressed packet and a launch happen on the same edge, the count decrements by 1.
- Undefined:
  - Every accepted packet is enqueued and sent.
  - `drop_count` is tied to 0.

## Test plan
- Reset, then push 32'hA1B2C3D4 with `router_free`=1 → `put_router` high for 4 cycles with payload A1, B2, C3, D4 starting 1 cycle after accept; `sent_count`=1; `fifo_count` returns to 0.
- Push 3 packets with `router_free` held 1 → three 4-cycle bursts, each separated by exactly 1 idle cycle; `sent_count`=3.
- Hold `router_free`=0 and push FIFO_DEPTH+1 packets → `pkt_ready` drops after 4 accepts; the 5th is held by the driver; `put_router` stays 0. Release `router_free` → 4 packets go out in push order.
- Drop `router_free` during byte index 1 → all 4 bytes still sent. The next packet waits in GAP/IDLE until `router_free` returns to 1.
- Assert `reset_n`=0 during byte index 2 with 2 packets queued → `put_router`=0 immediately; counts are 0; after release, no bytes are sent.
- With `NODE_SELF_DROP_EN` and NODEID=3, push 32'h13000001 and 32'h14000002 → only the second is transmitted; `drop_count`=1; `sent_count`=1.

Source files
------------

// File: rtl/node_packet_sender.sv
// Node-side transmit port: queues 32-bit packets in a FIFO and serializes each one as
// four MSB-first bytes on the router put/payload/free handshake. Optional self-drop: NODE_SELF_DROP_EN.
module node_packet_sender #(
    parameter int NODEID     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pkt_valid,
    input  logic [31:0]                   pkt_data,
    output logic                          pkt_ready,
    input  logic                          router_free,
    output logic                          put_router,
    output logic [7:0]                    payload_router,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   sent_count,
    output logic [7:0]                    drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   shift_q, shift_d;
    logic          put_q, put_d;
    logic [7:0]    payload_q, payload_d;
    logic [15:0]   sent_q, sent_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic          accept;
    logic          self_pkt;
    logic          push;
    logic          launch;
    logic [31:0]   head;

    assign pkt_ready = (count_q != CW'(FIFO_DEPTH));
    assign accept    = pkt_valid && pkt_ready;

`ifdef NODE_SELF_DROP_EN
    assign self_pkt  = (pkt_data[27:24] == 4'(NODEID));
`else
    assign self_pkt  = 1'b0;
`endif

    assign push    = accept && !self_pkt;
    // router_free only matters here; once a packet is launched it always completes.
    assign launch  = (state_q != ST_SEND) && (count_q != '0) && router_free;
    assign head    = mem_q[rd_ptr_q];
    assign count_d = count_q + CW'(push) - CW'(launch);

    // NOTE: the packet storage has no reset; the count and pointers alone decide what is valid,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_data;
        end
    end

    // NOTE: every sequential update uses <=, so all registers see the same pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (launch) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        put_d     = 1'b0;
        payload_d = 8'h00;
        sent_d    = sent_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (launch) begin
                    state_d   = ST_SEND;
                    idx_d     = 2'd0;
                    put_d     = 1'b1;
                    payload_d = head[31:24];
                    shift_d   = {head[23:0], 8'h00};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_GAP;
                    sent_d  = sent_q + 16'd1;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    put_d     = 1'b1;
                    payload_d = shift_q[31:24];
                    shift_d   = {shift_q[23:0], 8'h00};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            shift_q   <= '0;
            put_q     <= 1'b0;
            payload_q <= 8'h00;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            put_q     <= put_d;
            payload_q <= payload_d;
            sent_q    <= sent_d;
        end
    end

`ifdef NODE_SELF_DROP_EN
    logic [7:0] drop_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 8'h00;
        end else if (accept && self_pkt && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'h00;
`endif

    assign put_router     = put_q;
    assign payload_router = payload_q;
    assign fifo_count     = count_q;
    assign sent_count     = sent_q;

endmodule

// File: tb/tb_node_packet_sender.sv
// Directed and random bench for node_packet_sender against a queue-based transfer model.
module tb_node_packet_sender;

    localparam int         DEPTH  = 4;
    localparam logic [3:0] NODEID = 4'd3;

    logic        clock;
    logic        reset_n;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        pkt_ready;
    logic        router_free;
    logic        put_router;
    logic [7:0]  payload_router;
    logic [2:0]  fifo_count;
    logic [15:0] sent_count;
    logic [7:0]  drop_count;

    int n_compared;
    int n_mismatched;

    // Model: packets waiting, packet on the link and which byte of it is showing.
    logic [31:0] mq [$];
    logic [31:0] m_cur;
    int          m_idx;
    int          m_sent;
    int          m_drop;

    node_packet_sender #(
        .NODEID     (3),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pkt_valid      (pkt_valid),
        .pkt_data       (pkt_data),
        .pkt_ready      (pkt_ready),
        .router_free    (router_free),
        .put_router     (put_router),
        .payload_router (payload_router),
        .fifo_count     (fifo_count),
        .sent_count     (sent_count),
        .drop_count     (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_idx  = -1;
        m_cur  = '0;
        m_sent = 0;
        m_drop = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit launch;
        bit accept;
        bit self_pkt;
        launch   = (m_idx < 0) && (mq.size() > 0) && router_free;
        accept   = pkt_valid && (mq.size() < DEPTH);
        self_pkt = 1'b0;
`ifdef NODE_SELF_DROP_EN
        self_pkt = (pkt_data[27:24] == NODEID);
`endif
        if (m_idx >= 0) begin
            if (m_idx == 3) begin
                m_idx  = -1;
                m_sent = (m_sent + 1) % 65536;
            end else begin
                m_idx++;
            end
        end else if (launch) begin
            m_cur = mq.pop_front();
            m_idx = 0;
        end
        if (accept) begin
            if (self_pkt) begin
                if (m_drop < 255) m_drop++;
            end else begin
                mq.push_back(pkt_data);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] sh;
        logic [7:0]  exp_byte;
        sh       = (m_idx >= 0) ? (m_cur << (8 * m_idx)) : 32'h0;
        exp_byte = sh[31:24];
        check({tag, ".put"},     32'(put_router),     32'(m_idx >= 0));
        check({tag, ".payload"}, 32'(payload_router), 32'(exp_byte));
        check({tag, ".fifo"},    32'(fifo_count),     32'(mq.size()));
        check({tag, ".ready"},   32'(pkt_ready),      32'(mq.size() < DEPTH));
        check({tag, ".sent"},    32'(sent_count),     32'(m_sent));
        check({tag, ".drop"},    32'(drop_count),     32'(m_drop));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    task automatic push_one(input logic [31:0] data, input string tag);
        pkt_valid = 1'b1;
        pkt_data  = data;
        step(tag);
        pkt_valid = 1'b0;
    endtask

    initial begin
        int exp_sent;
        n_compared   = 0;
        n_mismatched = 0;
        reset_n      = 1'b0;
        pkt_valid    = 1'b0;
        pkt_data     = '0;
        router_free  = 1'b0;
        model_clear();
        #2;
        compare_all("reset");
        check("reset.ready_const", 32'(pkt_ready), 32'd1);
        #10;
        reset_n = 1'b1;

        // Single packet: bytes A1..D4 in the four cycles after launch.
        router_free = 1'b1;
        push_one(32'hA1B2C3D4, "t1.accept");
        check("t1.no_put_on_accept", 32'(put_router), 32'd0);
        step("t1.b0");
        check("t1.b0_const", 32'(payload_router), 32'hA1);
        step("t1.b1");
        check("t1.b1_const", 32'(payload_router), 32'hB2);
        step("t1.b2");
        check("t1.b2_const", 32'(payload_router), 32'hC3);
        step("t1.b3");
        check("t1.b3_const", 32'(payload_router), 32'hD4);
        step("t1.gap");
        check("t1.sent_const", 32'(sent_count), 32'd1);
        check("t1.fifo_const", 32'(fifo_count), 32'd0);

        // Three back-to-back packets, 5-cycle period.
        pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pkt_data = 32'h1234_5600 + 32'(i);
            step("t2.push");
        end
        pkt_valid = 1'b0;
        for (int i = 0; i < 16; i++) step("t2.run");
        check("t2.sent_const", 32'(sent_count), 32'd4);

        // Fill while the router is busy; the fifth offer is held off.
        router_free = 1'b0;
        pkt_valid   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pkt_data = 32'h5000_0000 + 32'((i < 4) ? i : 4);
            step("t3.fill");
        end
        check("t3.ready_full", 32'(pkt_ready), 32'd0);
        check("t3.fifo_full", 32'(fifo_count), 32'd4);
        check("t3.put_idle", 32'(put_router), 32'd0);
        pkt_valid   = 1'b0;
        router_free = 1'b1;
        for (int i = 0; i < 22; i++) step("t3.drain");
        check("t3.sent_const", 32'(sent_count), 32'd8);

        // router_free drops mid-packet: transfer completes, next one waits.
        push_one(32'h6100_0011, "t4.accept");
        step("t4.b0");
        step("t4.b1");
        router_free = 1'b0;
        push_one(32'h6200_0022, "t4.b2");
        step("t4.b3");
        for (int i = 0; i < 4; i++) step("t4.wait");
        check("t4.held_put", 32'(put_router), 32'd0);
        check("t4.held_fifo", 32'(fifo_count), 32'd1);
        router_free = 1'b1;
        for (int i = 0; i < 6; i++) step("t4.resume");
        check("t4.sent_const", 32'(sent_count), 32'd10);

        // Asynchronous reset during byte 2 with two packets queued.
        pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pkt_data = 32'h7700_0000 + 32'(i);
            step("t5.push");
        end
        pkt_valid = 1'b0;
        step("t5.b2");
        check("t5.pre_fifo", 32'(fifo_count), 32'd2);
        reset_n = 1'b0;
        #1;
        model_clear();
        compare_all("t5.in_reset");
        check("t5.put_const", 32'(put_router), 32'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) step("t5.after");

        // Self-addressed packet (dropped only when the feature is built in).
        pkt_valid = 1'b1;
        pkt_data  = 32'h1300_0001;
        step("t6.push_self");
        pkt_data  = 32'h1400_0002;
        step("t6.push_other");
        pkt_valid = 1'b0;
        for (int i = 0; i < 12; i++) step("t6.run");
`ifdef NODE_SELF_DROP_EN
        exp_sent = 1;
        check("t6.drop_const", 32'(drop_count), 32'd1);
`else
        exp_sent = 2;
        check("t6.drop_const", 32'(drop_count), 32'd0);
`endif
        check("t6.sent_const", 32'(sent_count), 32'(exp_sent));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            pkt_valid   = 1'($urandom_range(0, 1));
            pkt_data    = $urandom;
            router_free = ($urandom_range(0, 9) < 7);
            step("rand");
        end
        pkt_valid   = 1'b0;
        router_free = 1'b1;
        for (int i = 0; i < 25; i++) step("rand.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
